// File: rtl/out_buf_drain.sv
// Drains the per-compute-unit output buffers of the cluster, one word per unit,
// into a valid/ready stream after each start pulse.
module out_buf_drain #(
    parameter int CU_NUM = 8,
    parameter int DAT_W  = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      abort_i,
    output logic [$clog2(CU_NUM)-1:0] cu_sel_o,
    input  logic [DAT_W-1:0]          cu_dat_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [DAT_W-1:0]          m_data_o,
    output logic [$clog2(CU_NUM)-1:0] m_idx_o,
    output logic                      m_last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      start_drop_o
);

    localparam int               SEL_W    = $clog2(CU_NUM);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CU_NUM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DAT_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               drop_q, drop_d;
    logic               armed_q, armed_d;
    logic               capture;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        drop_d  = start_i && (state_q != IDLE);
        // Start is not honoured in the first cycle after reset release.
        armed_d = 1'b1;
        capture = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            sel_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i && armed_q) begin
                        sel_d   = '0;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
                STREAM: begin
                    if (valid_q && m_ready_i) begin
                        if (last_q) begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            capture = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The cluster returns cu_dat_i for the current select in the same cycle.
        if (capture) begin
            data_d  = cu_dat_i;
            idx_d   = sel_q;
            valid_d = 1'b1;
            last_d  = (sel_q == LAST_SEL);
            if (sel_q != LAST_SEL) begin
                sel_d = sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            armed_q <= armed_d;
        end
    end

    assign cu_sel_o     = sel_q;
    assign m_valid_o    = valid_q;
    assign m_data_o     = data_q;
    assign m_idx_o      = idx_q;
    assign m_last_o     = last_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign start_drop_o = drop_q;

endmodule

// File: doc/out_buf_drain.md
OUT_BUF_DRAIN -- requirements
Module: out_buf_drain

Interface
REQ-001 Parameter CU_NUM, default 8, number of compute units drained per job; legal values are 2 and above.
REQ-002 Parameter DAT_W, default 256, width of one compute-unit output buffer word.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 start_i  input  1  one-cycle pulse from the compute cluster (total-finish / total-chunk-end) requesting a drain.
REQ-006 abort_i  input  1  synchronous abort of the current drain.
REQ-007 cu_sel_o  output  $clog2(CU_NUM)  compute-unit output-buffer select driven to the cluster.
REQ-008 cu_dat_i  input  DAT_W  cluster output data for the unit selected by cu_sel_o, combinational, same cycle.
REQ-009 m_valid_o  output  1  output word valid.
REQ-010 m_ready_i  input  1  downstream ready.
REQ-011 m_data_o  output  DAT_W  output word.
REQ-012 m_idx_o  output  $clog2(CU_NUM)  compute-unit index of m_data_o.
REQ-013 m_last_o  output  1  marks the word of unit CU_NUM-1.
REQ-014 busy_o  output  1  high while state is not IDLE.
REQ-015 done_o  output  1  one-cycle pulse on drain completion.
REQ-016 start_drop_o  output  1  one-cycle pulse when start_i is ignored.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, and STREAM.
REQ-018 In IDLE with start_i=1, the block SHALL set cu_sel_o to 0 and go to LOAD.
REQ-019 In LOAD, the block SHALL capture cu_dat_i into m_data_o, set m_idx_o to cu_sel_o, set m_valid_o to 1, set m_last_o to (cu_sel_o==CU_NUM-1), increment cu_sel_o, and go to STREAM.
REQ-020 In STREAM on handshake (m_valid_o & m_ready_i) with m_last_o=0, the block SHALL capture the next word in the same cycle with identical update rules, giving one word per cycle under continuous ready.
REQ-021 In STREAM on handshake with m_last_o=1, the block SHALL clear m_valid_o and m_last_o, go to IDLE, and assert done_o for exactly the next cycle.
REQ-022 cu_sel_o SHALL NOT increment past CU_NUM-1; it holds CU_NUM-1 after the last capture.
REQ-023 While m_valid_o=1 and m_ready_i=0, m_data_o, m_idx_o, m_last_o, and cu_sel_o SHALL hold stable.
REQ-024 Exactly CU_NUM words SHALL be emitted per drain, with indices 0..CU_NUM-1 in ascending order.
REQ-025 First-word latency SHALL be 2 cycles from start_i: the LOAD cycle, after which m_valid_o is high.
REQ-026 A start_i while busy_o=1 SHALL be ignored and SHALL pulse start_drop_o in the next cycle.
REQ-027 start_i coincident with a done_o cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-028 abort_i, in any state, SHALL force IDLE next cycle, clear m_valid_o and m_last_o, reset cu_sel_o to 0, and suppress done_o.
REQ-029 abort_i SHALL take priority over a same-cycle handshake or start_i.
REQ-030 m_data_o SHALL be registered, with no combinational path from cu_dat_i or m_ready_i to any output.
REQ-031 The upstream cluster SHALL keep its output buffers stable from start_i until done_o or abort; the block SHALL NOT check this.

Reset
REQ-032 While rst_ni=0, the block SHALL hold state=IDLE and all outputs at 0, including cu_sel_o, m_data_o, and m_idx_o.
REQ-033 Reset asserted mid-drain SHALL discard the drain with no done_o; after release the block SHALL wait for a new start_i.
REQ-034 Reset release SHALL be synchronized externally; the block SHALL NOT act on start_i in the first cycle after release.

Verification (CU_NUM=4, DAT_W=32, cu_dat_i = 0xA0+cu_sel_o)
REQ-035 ready=1 constant, start pulse at cycle 0 -> m_valid_o high cycles 2..5; data 0xA0, 0xA1, 0xA2, 0xA3; m_last_o only at cycle 5; done_o at cycle 6; busy_o cycles 1..5.
REQ-036 ready toggled 1,0,0,1,... -> no word lost or duplicated; data and index stable during stalls; done_o one cycle after the 0xA3 handshake.
REQ-037 start_i re-pulsed at cycle 3 of a drain -> start_drop_o at cycle 4; the drain still emits exactly 4 words.
REQ-038 abort_i while the word with m_idx_o=2 is stalled -> next cycle m_valid_o=0, busy_o=0, cu_sel_o=0, no done_o; a new start gives 0xA0 first.
REQ-039 rst_ni low asynchronously mid-drain -> outputs 0 immediately, not at a clock edge; after release and a new start, full 4-word sequence.
REQ-040 start_i in the done_o cycle -> second drain begins; back-to-back totals 8 words, two done_o pulses.
